// File: rtl/led_pssr_scan_if.sv
// Handshake and strobe bundle between the row-scan sequencer, the frame
// source and the panel/PSSR side.
//   master : the sequencer (drives requests, PSSR controls, panel strobes)
//   slave  : the environment (drives enable and row_ack)
// Signals:
//   enable, row_ack                  -> sequencer
//   row_req, load, sel, bit_valid,
//   latch, oe_n, row_addr, disp_row,
//   frame_done, busy                 <- sequencer
interface led_pssr_scan_if #(
    parameter int ROW_W = 4
);
    logic             enable;
    logic             row_req;
    logic             row_ack;
    logic             load;
    logic [1:0]       sel;
    logic             bit_valid;
    logic             latch;
    logic             oe_n;
    logic [ROW_W-1:0] row_addr;
    logic [ROW_W-1:0] disp_row;
    logic             frame_done;
    logic             busy;

    modport master (
        input  enable, row_ack,
        output row_req, load, sel, bit_valid, latch, oe_n,
               row_addr, disp_row, frame_done, busy
    );

    modport slave (
        output enable, row_ack,
        input  row_req, load, sel, bit_valid, latch, oe_n,
               row_addr, disp_row, frame_done, busy
    );
endinterface

// File: rtl/led_pssr_scan_ctrl.sv
// Row-scan sequencer for the LED panel shift path. Fetches one row from the
// frame source, loads the PSSR, walks its word select while the row shifts
// out, then latches the row into the panel and blanks it briefly.
// Ports:
//   clk  : rising-edge clock shared with the PSSR
//   rst  : synchronous active-high reset
//   bus  : led_pssr_scan_if.master (enable/row_ack in, all strobes out)
//
// state | meaning
// IDLE  | stopped, panel dark, waiting for enable
// REQ   | row_req high until row_ack
// LOAD  | one-cycle PSSR parallel load
// SHIFT | NUM_WORDS*WORD_W shift cycles, sel follows bit_cnt
// TAIL  | one cycle so the last registered bit drains
// LATCH | one-cycle panel latch, disp_row updated
// BLANK | BLANK_CYC cycles of oe_n high, then next row or IDLE
module led_pssr_scan_ctrl #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int NUM_ROWS  = 16,
    parameter int BLANK_CYC = 4
) (
    input logic            clk,
    input logic            rst,
    led_pssr_scan_if.master bus
);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int BITS  = NUM_WORDS * WORD_W;
    localparam int CNT_W = $clog2(BITS);
    localparam int BLK_W = $clog2(BLANK_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYC - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, LOAD, SHIFT, TAIL, LATCH, BLANK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [BLK_W-1:0] blank_cnt;
    logic [ROW_W-1:0] row_addr;
    logic [ROW_W-1:0] disp_row;
    // A row has been latched since reset/IDLE, so the panel may be lit
    // while the next row shifts in.
    logic             shown;

    assign bit_cnt_inc  = bit_cnt + 1'b1;
    assign bus.row_addr = row_addr;
    assign bus.disp_row = disp_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            blank_cnt      <= '0;
            row_addr       <= '0;
            disp_row       <= '0;
            shown          <= 1'b0;
            bus.row_req    <= 1'b0;
            bus.load       <= 1'b0;
            bus.sel        <= 2'b00;
            bus.bit_valid  <= 1'b0;
            bus.latch      <= 1'b0;
            bus.oe_n       <= 1'b1;
            bus.frame_done <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.load       <= 1'b0;
            bus.latch      <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.row_req    <= 1'b0;
            // PSSR output is registered, so a bit is on data_out one cycle
            // after the shift cycle that selected it.
            bus.bit_valid  <= (state == SHIFT);

            case (state)
                IDLE: begin
                    shown    <= 1'b0;
                    bus.oe_n <= 1'b1;
                    if (bus.enable) begin
                        state       <= REQ;
                        bus.row_req <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.row_ack) begin
                        state    <= LOAD;
                        bus.load <= 1'b1;
                    end else begin
                        bus.row_req <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                    bus.sel <= 2'b00;
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        state   <= TAIL;
                        bus.sel <= 2'b11;
                    end else begin
                        bit_cnt <= bit_cnt_inc;
                        bus.sel <= bit_cnt_inc[CNT_W-1 -: 2];
                    end
                end
                TAIL: begin
                    state          <= LATCH;
                    bus.latch      <= 1'b1;
                    bus.oe_n       <= 1'b1;
                    disp_row       <= row_addr;
                    bus.frame_done <= (row_addr == LAST_ROW);
                    shown          <= 1'b1;
                end
                LATCH: begin
                    state     <= BLANK;
                    blank_cnt <= BLK_LOAD;
                end
                BLANK: begin
                    if (blank_cnt == '0) begin
                        row_addr <= (row_addr == LAST_ROW) ? '0 : row_addr + 1'b1;
                        if (bus.enable) begin
                            state       <= REQ;
                            bus.row_req <= 1'b1;
                            bus.oe_n    <= ~shown;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            shown    <= 1'b0;
                        end
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_led_pssr_scan_ctrl.sv
module tb_led_pssr_scan_ctrl;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 4;
    localparam int NUM_ROWS  = 16;
    localparam int BLANK_CYC = 4;
    localparam int ROW_W     = 4;
    localparam int SHIFT_N   = NUM_WORDS * WORD_W;
    localparam int LATCH_POS = SHIFT_N + 2;           // position of the latch cycle after LOAD
    localparam int LAST_POS  = LATCH_POS + BLANK_CYC; // last blank cycle

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_pssr_scan_if #(.ROW_W(ROW_W)) bus ();

    led_pssr_scan_ctrl #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS),
        .NUM_ROWS(NUM_ROWS), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // behavioural model: phase 0 idle, 1 waiting for ack, 2 running with
    // position counted from the LOAD cycle (0) through the last blank cycle
    int   m_phase, m_pos, m_row, m_disp, m_sel;
    logic m_shown;

    // bookkeeping for literal expectations
    int   cycle, req_run, max_req_run, latch_cnt, fd_cnt, last_latch, bv_run, prev_sel;
    logic check_period;
    int   ack_mode, ack_delay;
    logic [127:0] stream;
    logic [31:0]  words [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cycle);
        end
    endtask

    task automatic sample();
        logic in2;
        @(negedge clk);
        cycle++;
        in2 = (m_phase == 2);
        chk("busy",       bus.busy,       m_phase != 0);
        chk("row_req",    bus.row_req,    m_phase == 1);
        chk("load",       bus.load,       in2 && m_pos == 0);
        chk("bit_valid",  bus.bit_valid,  in2 && m_pos >= 2 && m_pos <= SHIFT_N + 1);
        chk("latch",      bus.latch,      in2 && m_pos == LATCH_POS);
        chk("frame_done", bus.frame_done, in2 && m_pos == LATCH_POS && m_row == NUM_ROWS - 1);
        chk("oe_n",       bus.oe_n,
            !(m_shown && (m_phase == 1 || (in2 && m_pos <= SHIFT_N + 1))));
        chk("sel",        bus.sel,        m_sel);
        chk("row_addr",   bus.row_addr,   m_row);
        chk("disp_row",   bus.disp_row,   m_disp);

        if (bus.row_req) begin
            req_run++;
            if (req_run > max_req_run) max_req_run = req_run;
        end else begin
            req_run = 0;
        end
        if (bus.latch) begin
            latch_cnt++;
            if (check_period && last_latch >= 0)
                chk("latch_period", cycle - last_latch, 136);
            last_latch = cycle;
        end
        if (bus.frame_done) begin
            fd_cnt++;
            chk("fd_disp_row", bus.disp_row, 15);
        end
        if (bus.bit_valid) begin
            if (bv_run < SHIFT_N)
                stream[127 - bv_run] = words[prev_sel][31 - (bv_run % 32)];
            bv_run++;
        end else if (bv_run > 0) begin
            chk("bv_length", bv_run, 128);
            chk("bit_stream", stream, {32'h8000_0001, 96'h0});
            bv_run = 0;
            stream = '0;
        end
        prev_sel = bus.sel;
    endtask

    task automatic model_step(input logic en, input logic ack, input logic r);
        if (r) begin
            m_phase = 0; m_pos = 0; m_row = 0; m_disp = 0; m_sel = 0; m_shown = 1'b0;
        end else if (m_phase == 0) begin
            m_shown = 1'b0;
            if (en) m_phase = 1;
        end else if (m_phase == 1) begin
            if (ack) begin m_phase = 2; m_pos = 0; end
        end else if (m_pos == LAST_POS) begin
            m_row = (m_row + 1) % NUM_ROWS;
            m_phase = en ? 1 : 0;
            if (!en) m_shown = 1'b0;
        end else begin
            m_pos++;
            if (m_pos >= 1 && m_pos <= SHIFT_N) m_sel = (m_pos - 1) / 32;
            if (m_pos == SHIFT_N + 1) m_sel = 3;
            if (m_pos == LATCH_POS) begin m_disp = m_row; m_shown = 1'b1; end
        end
    endtask

    task automatic drive(input logic en, input logic r);
        logic ack;
        case (ack_mode)
            0:       ack = 1'b1;
            1:       ack = bus.row_req ? (req_run > ack_delay) : ($urandom_range(0, 3) == 0);
            default: ack = ($urandom_range(0, 2) == 0);
        endcase
        bus.enable  = en;
        bus.row_ack = ack;
        rst         = r;
        model_step(en, ack, r);
        if (r) begin
            bv_run = 0; stream = '0; last_latch = -1; req_run = 0;
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event cycle=%0d", name, cycle);
    endtask

    initial begin
        int guard, r0, l0;
        logic en;
        words[0] = 32'h8000_0001; words[1] = '0; words[2] = '0; words[3] = '0;
        cycle = 0; req_run = 0; max_req_run = 0; latch_cnt = 0; fd_cnt = 0;
        last_latch = -1; bv_run = 0; prev_sel = 0; stream = '0;
        check_period = 1'b0; ack_mode = 0; ack_delay = 0;
        bus.enable = 1'b0; bus.row_ack = 1'b0; rst = 1'b1;
        model_step(1'b0, 1'b0, 1'b1);

        // reset state, then continuous scan with zero-wait ack over a full frame
        sample();
        chk("rst_oe_n", bus.oe_n, 1);
        chk("rst_busy", bus.busy, 0);
        drive(1'b0, 1'b1);
        check_period = 1'b1;
        guard = 0;
        while (latch_cnt < 16 && guard < 3000) begin
            sample(); drive(1'b1, 1'b0); guard++;
        end
        if (latch_cnt < 16) timeout("frame_latches");
        chk("frame_done_count", fd_cnt, 1);
        guard = 0;
        sample();
        while (!bus.row_req && guard < 20) begin
            drive(1'b1, 1'b0); sample(); guard++;
        end
        chk("wrap_row_addr", bus.row_addr, 0);
        drive(1'b1, 1'b0);
        check_period = 1'b0;

        // ack delayed by 5 cycles in REQ, spurious acks elsewhere
        ack_mode = 1; ack_delay = 5; max_req_run = 0;
        l0 = latch_cnt; guard = 0;
        while (latch_cnt < l0 + 3 && guard < 1000) begin
            sample(); drive(1'b1, 1'b0); guard++;
        end
        if (latch_cnt < l0 + 3) timeout("delayed_ack_rows");
        chk("row_req_hold", max_req_run, 6);

        // enable dropped early in SHIFT
        ack_mode = 0; guard = 0;
        sample();
        while (!bus.load && guard < 300) begin
            drive(1'b1, 1'b0); sample(); guard++;
        end
        r0 = bus.row_addr; l0 = latch_cnt;
        drive(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin sample(); drive(1'b1, 1'b0); end
        guard = 0;
        sample();
        while (bus.busy && guard < 300) begin
            drive(1'b0, 1'b0); sample(); guard++;
        end
        chk("drop_latched", latch_cnt - l0, 1);
        chk("drop_idle_row", bus.row_addr, (r0 + 1) % NUM_ROWS);
        for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0); sample(); end
        drive(1'b1, 1'b0);
        sample();
        chk("resume_row", bus.row_addr, (r0 + 1) % NUM_ROWS);
        chk("resume_req", bus.row_req, 1);

        // reset mid-SHIFT
        guard = 0;
        while (!bus.load && guard < 300) begin
            drive(1'b1, 1'b0); sample(); guard++;
        end
        drive(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) begin sample(); drive(1'b1, 1'b0); end
        sample();
        drive(1'b1, 1'b1);
        sample();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_oe_n", bus.oe_n, 1);
        chk("midrst_row", bus.row_addr, 0);
        chk("midrst_latch", bus.latch, 0);
        drive(1'b1, 1'b0);

        // randomized traffic
        ack_mode = 2; en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            sample();
            if ($urandom_range(0, 199) == 0) en = ~en;
            drive(en, $urandom_range(0, 1499) == 0);
        end

        sample();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
